// File: rtl/serial_record_loader.sv
// Deserializes LANES-bit beats into MSB-aligned records of (feat+1) fields and
// emits one RAM write per completed record, with no bubble between records.
module serial_record_loader #(
   parameter int ADDR_WIDTH   = 12,
   parameter int MAX_FEATURES = 15,
   parameter int FIELD_WIDTH  = 16,
   parameter int LANES        = 1,
   parameter int DATA_WIDTH   = FIELD_WIDTH * (MAX_FEATURES + 1)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] num_dp,
   input  logic [3:0]            feat,
   input  logic                  ser_valid,
   input  logic [LANES-1:0]      ser,
   output logic                  ser_ready,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  flag,
   output logic                  busy,
   output logic                  done
);

   localparam int PW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t                 state_reg, state_next;
   logic [3:0]             feat_reg;
   logic [ADDR_WIDTH-1:0]  num_dp_reg;
   logic [ADDR_WIDTH-1:0]  rec_reg;
   logic [PW-1:0]          ptr_reg;
   logic [DATA_WIDTH-1:0]  asm_reg;
   logic                   wr_en_reg;
   logic [ADDR_WIDTH-1:0]  addr_reg;
   logic [DATA_WIDTH-1:0]  data_reg;
   logic                   flag_reg;

   logic [3:0]             feat_clamp;
   logic [PW-1:0]          base_in;
   logic [PW-1:0]          base_q;
   logic [PW-1:0]          flag_off;
   logic                   accept;
   logic                   last_beat;
   logic                   final_rec;
   logic                   covers_flag;
   logic [DATA_WIDTH-1:0]  asm_fill;

   always_comb begin
      feat_clamp  = (int'(feat) > MAX_FEATURES) ? 4'(MAX_FEATURES) : feat;
      base_in     = PW'(DATA_WIDTH - FIELD_WIDTH * (int'(feat_clamp) + 1));
      base_q      = PW'(DATA_WIDTH - FIELD_WIDTH * (int'(feat_reg) + 1));
      flag_off    = PW'(int'(base_q) + (FIELD_WIDTH / 2) * (int'(feat_reg) + 1));
      accept      = ser_valid && (state_reg == LOAD);
      last_beat   = accept && (int'(ptr_reg) + LANES == DATA_WIDTH);
      final_rec   = last_beat && (rec_reg == num_dp_reg);
      covers_flag = (int'(ptr_reg) <= int'(flag_off)) &&
                    (int'(flag_off) < int'(ptr_reg) + LANES);
      // asm is zero above the pointer, so OR-ing the shifted beat places it exactly
      asm_fill    = asm_reg | ({{(DATA_WIDTH-LANES){1'b0}}, ser} << ptr_reg);
   end

   always_ff @(posedge CLK) begin
      if (RST) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      ser_ready  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) state_next = LOAD;
         end
         LOAD: begin
            ser_ready = 1'b1;
            busy      = 1'b1;
            if (final_rec) state_next = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_next = LOAD;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         feat_reg   <= '0;
         num_dp_reg <= '0;
         rec_reg    <= '0;
         ptr_reg    <= '0;
         asm_reg    <= '0;
         wr_en_reg  <= 1'b0;
         addr_reg   <= '0;
         data_reg   <= '0;
         flag_reg   <= 1'b0;
      end else begin
         wr_en_reg <= 1'b0;
         if (state_reg != LOAD && start) begin
            feat_reg   <= feat_clamp;
            num_dp_reg <= num_dp;
            rec_reg    <= '0;
            ptr_reg    <= base_in;
            asm_reg    <= '0;
            flag_reg   <= 1'b0;
         end else if (accept) begin
            if (rec_reg == num_dp_reg && covers_flag) flag_reg <= 1'b1;
            if (last_beat) begin
               wr_en_reg <= 1'b1;
               addr_reg  <= rec_reg;
               data_reg  <= asm_fill;
               ptr_reg   <= base_q;
               asm_reg   <= '0;
               if (!final_rec) rec_reg <= rec_reg + ADDR_WIDTH'(1);
            end else begin
               asm_reg <= asm_fill;
               ptr_reg <= ptr_reg + PW'(LANES);
            end
         end
      end
   end

   assign wr_en = wr_en_reg;
   assign addr  = addr_reg;
   assign data  = data_reg;
   assign flag  = flag_reg;

endmodule

// File: tb/tb_serial_record_loader.sv
// Scoreboard bench for serial_record_loader: one LANES=1 and one LANES=4 instance,
// expected writes queued as records are driven and compared on every wr_en.
module tb_serial_record_loader;
   localparam int AW = 12;
   localparam int DW = 256;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic          start1, ser_valid1, ser_ready1, wr_en1, flag1, busy1, done1;
   logic [AW-1:0] num_dp1, addr1;
   logic [3:0]    feat1;
   logic [0:0]    ser1;
   logic [DW-1:0] data1;

   logic          start4, ser_valid4, ser_ready4, wr_en4, flag4, busy4, done4;
   logic [AW-1:0] num_dp4, addr4;
   logic [3:0]    feat4;
   logic [3:0]    ser4;
   logic [DW-1:0] data4;

   serial_record_loader #(.LANES(1)) u_dut1 (
      .CLK(clk), .RST(rst), .start(start1), .num_dp(num_dp1), .feat(feat1),
      .ser_valid(ser_valid1), .ser(ser1), .ser_ready(ser_ready1), .wr_en(wr_en1),
      .addr(addr1), .data(data1), .flag(flag1), .busy(busy1), .done(done1));

   serial_record_loader #(.LANES(4)) u_dut4 (
      .CLK(clk), .RST(rst), .start(start4), .num_dp(num_dp4), .feat(feat4),
      .ser_valid(ser_valid4), .ser(ser4), .ser_ready(ser_ready4), .wr_en(wr_en4),
      .addr(addr4), .data(data4), .flag(flag4), .busy(busy4), .done(done4));

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   exp_t exp1[$];
   exp_t exp4[$];
   int wr_times4[$];
   logic [DW-1:0] recs[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] rand_rec(input int nbits);
      logic [DW-1:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      if (nbits < DW) v = v & ((DW'(1) << nbits) - DW'(1));
      return v;
   endfunction

   always @(negedge clk) begin
      if (wr_en1) begin
         if (exp1.size() == 0) check("wr1_unexpected", 1, 0);
         else begin
            exp_t e;
            e = exp1.pop_front();
            check("wr1_addr", addr1, e.addr);
            check("wr1_data", data1, e.data);
            check("wr1_done", done1, e.last);
         end
      end
      if (wr_en4) begin
         wr_times4.push_back(cyc);
         if (exp4.size() == 0) check("wr4_unexpected", 1, 0);
         else begin
            exp_t e;
            e = exp4.pop_front();
            check("wr4_addr", addr4, e.addr);
            check("wr4_data", data4, e.data);
            check("wr4_done", done4, e.last);
         end
      end
   end

   task automatic beat1(input logic b, input bit gaps);
      if (gaps) begin
         while ($urandom_range(0, 1) == 1) begin
            ser_valid1 = 1'b0;
            ser1 = 1'($urandom);
            tick();
         end
      end
      ser_valid1 = 1'b1;
      ser1[0] = b;
      tick();
      ser_valid1 = 1'b0;
   endtask

   // Drives every record in recs through the LANES=1 instance; poke >= 0 pulses
   // start and alters feat/num_dp at that bit of record 0.
   task automatic load1(input int f, input bit gaps, input int poke);
      int n;
      int off;
      int nrec;
      n = 16 * (f + 1);
      off = 8 * (f + 1);
      nrec = recs.size();
      start1 = 1'b1; feat1 = 4'(f); num_dp1 = AW'(nrec - 1);
      tick();
      start1 = 1'b0;
      check("busy1_start", busy1, 1);
      check("done1_clr", done1, 0);
      check("flag1_clr", flag1, 0);
      for (int r = 0; r < nrec; r++) begin
         logic [DW-1:0] v;
         exp_t e;
         v = recs[r];
         e.addr = AW'(r);
         e.data = v << (DW - n);
         e.last = (r == nrec - 1);
         exp1.push_back(e);
         for (int k = 0; k < n; k++) begin
            if (r == 0 && k == poke) begin
               start1 = 1'b1; feat1 = 4'(f + 5); num_dp1 = num_dp1 + AW'(3);
            end
            beat1(v[k], gaps);
            start1 = 1'b0;
            if (r == nrec - 1 && (k == off - 1 || k == off))
               check("flag1", flag1, (k == off));
         end
      end
      check("done1", done1, 1);
      check("ready1_done", ser_ready1, 0);
   endtask

   task automatic load4(input int f, input int nrec);
      int n;
      n = 16 * (f + 1);
      start4 = 1'b1; feat4 = 4'(f); num_dp4 = AW'(nrec - 1);
      tick();
      start4 = 1'b0;
      wr_times4.delete();
      for (int r = 0; r < nrec; r++) begin
         logic [DW-1:0] v;
         exp_t e;
         v = rand_rec(n);
         e.addr = AW'(r);
         e.data = v << (DW - n);
         e.last = (r == nrec - 1);
         exp4.push_back(e);
         for (int j = 0; j < n / 4; j++) begin
            check("ready4", ser_ready4, 1);
            ser_valid4 = 1'b1;
            ser4 = v[4*j +: 4];
            tick();
         end
      end
      ser_valid4 = 1'b0;
      check("done4", done4, 1);
      tick();
      for (int i = 1; i < wr_times4.size(); i++)
         check("wr4_spacing", DW'(wr_times4[i] - wr_times4[i-1]), 8);
      check("wr4_count", DW'(wr_times4.size()), DW'(nrec));
   endtask

   task automatic check_reset1();
      check("rst_ready", ser_ready1, 0);
      check("rst_wr_en", wr_en1, 0);
      check("rst_addr", addr1, 0);
      check("rst_data", data1, 0);
      check("rst_flag", flag1, 0);
      check("rst_busy", busy1, 0);
      check("rst_done", done1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] v;
      rst = 1'b1;
      start1 = 0; ser_valid1 = 0; ser1 = 0; feat1 = 0; num_dp1 = 0;
      start4 = 0; ser_valid4 = 0; ser4 = 0; feat4 = 0; num_dp4 = 0;
      repeat (3) tick();
      check_reset1();
      rst = 1'b0;
      tick();

      recs = '{DW'(16'hA5A5), DW'(16'h3C3C)};
      load1(0, 1'b0, -1);

      recs = '{rand_rec(256)};
      load1(15, 1'b0, -1);

      recs.delete();
      for (int i = 0; i < 5; i++) recs.push_back(rand_rec(64));
      load1(3, 1'b1, -1);

      recs = '{rand_rec(48), rand_rec(48)};
      load1(2, 1'b0, 10);

      // abort partway through record 1; only record 0 may be written
      start1 = 1'b1; feat1 = 4'd1; num_dp1 = AW'(3);
      tick();
      start1 = 1'b0;
      begin
         exp_t e;
         v = rand_rec(32);
         e.addr = '0; e.data = v << (DW - 32); e.last = 1'b0;
         exp1.push_back(e);
      end
      for (int k = 0; k < 32; k++) beat1(v[k], 1'b0);
      v = rand_rec(32);
      for (int k = 0; k < 20; k++) beat1(v[k], 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset1();
      for (int i = 0; i < 40; i++) begin
         ser_valid1 = 1'b1;
         ser1 = 1'($urandom);
         tick();
      end
      ser_valid1 = 1'b0;
      check("idle_ready", ser_ready1, 0);
      recs = '{rand_rec(16)};
      load1(0, 1'b0, -1);

      load4(1, 3);

      repeat (3) tick();
      check("sb1_empty", DW'(exp1.size()), 0);
      check("sb4_empty", DW'(exp4.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
